code_mem_loader: RTL
====================

CODE_MEM_LOADER -- requirements
Module: code_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, code-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, largest legal program length in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin or restart a load.
REQ-006 SHALL have port in_valid, input, 1, byte-stream valid.
REQ-007 SHALL have port in_data, input, 8, byte-stream data.
REQ-008 SHALL have port in_ready, output, 1, byte-stream ready.
REQ-009 SHALL have port mem_we, output, 1, code-memory write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, code-memory word address.
REQ-011 SHALL have port mem_wdata, output, 32, code-memory write data.
REQ-012 SHALL have port cpu_run, output, 1, releases the processor once the program is resident.
REQ-013 SHALL have port busy, output, 1, load in progress.
REQ-014 SHALL have port err, output, 1, sticky header error.

Function
REQ-015 SHALL transfer a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL use states IDLE, HDR_HI, HDR_LO, LOAD, FLUSH, DONE, ERR.
REQ-017 SHALL hold in_ready=1 only in HDR_HI, HDR_LO and LOAD.
REQ-018 SHALL go from IDLE to HDR_HI on start=1, and from DONE or ERR to HDR_HI on start=1, clearing err and cpu_run; start in any other state SHALL be ignored.
REQ-019 SHALL take byte 0 as count[15:8] and byte 1 as count[7:0] of a 16-bit big-endian word count N.
REQ-020 SHALL go from HDR_LO to DONE when N=0, to ERR when N>MAX_WORDS, otherwise to LOAD.
REQ-021 SHALL assemble each 4 consecutive LOAD bytes big-endian (first byte = bits 31:24) into one word.
REQ-022 SHALL, on the edge accepting the 4th byte of word k, register mem_we=1, mem_addr=k (counting from 0) and mem_wdata=the word for exactly one cycle.
REQ-023 SHALL go from LOAD to FLUSH on the edge that accepts the last byte of word N-1, with the final mem_we pulse occurring in FLUSH.
REQ-024 SHALL go from FLUSH to DONE unconditionally one cycle later.
REQ-025 SHALL keep mem_addr and mem_wdata stable when mem_we=0.
REQ-026 SHALL use an 11-bit word counter that never wraps, since N<=MAX_WORDS is enforced.
REQ-027 SHALL drive busy=1 in HDR_HI, HDR_LO, LOAD and FLUSH; cpu_run=1 only in DONE; err=1 only in ERR.
REQ-028 SHALL hold state, byte position and partial word unchanged while in_valid=0 mid-word (no timeout).
REQ-029 SHALL discard any partial word or header when start arrives in DONE or ERR.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-load, immediately force state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, err=0, and clear the counter and byte position.
REQ-031 SHALL never emit a partial-word write after reset deassertion.

Structure
REQ-032 SHALL place the state enumeration, header byte count (2) and bytes-per-word (4) in a shared package with the other processor constants.
REQ-033 SHALL use one sub-module, byte_assembler: a 4-byte shift register with a byte index and a word_valid pulse; the FSM, counter and memory-port registers SHALL stay in code_mem_loader.

Verification
REQ-034 Start, header 00 02, bytes 20 01 00 05 8C 22 00 00 -> writes addr0=0x20010005 then addr1=0x8C220000; cpu_run=1 one cycle after the final mem_we, busy=0.
REQ-035 Header 00 00 -> no mem_we pulse; DONE entered directly after HDR_LO; cpu_run=1.
REQ-036 Header 04 01 (1025) -> ERR, err=1, in_ready=0, no writes; a later start clears err and accepts a new header.
REQ-037 in_valid toggling 1/0 every cycle across a 3-word load -> same addresses and data as the back-to-back case, one mem_we per word.
REQ-038 rst_n low after 2 of 4 bytes of word 1 -> all outputs zero at once; after restart with a fresh stream, word 0 is rewritten at addr 0 and no stale bytes appear.
REQ-039 Header 04 00 (1024) and 4096 bytes -> last write at addr 1023 with no address wrap, then DONE.

Source files
------------

// File: rtl/code_mem_loader_pkg.sv
// Shared constants and types for the code-memory loader and the rest of the processor.
// The loader reads a 2-byte header, then streams big-endian 32-bit words into code memory.
package code_mem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int COUNT_W        = 16;
    localparam int WORD_CNT_W     = 11;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        LOAD,
        FLUSH,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/code_mem_loader_byte_assembler.sv
// Packs four consecutive bytes, first byte into bits 31:24, into one word.
// word_valid_o fires combinationally alongside the 4th byte so the caller can register the write.
module byte_assembler
    import code_mem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                byte_valid_i,
    input  logic [BYTE_W-1:0]   byte_i,
    output logic                word_valid_o,
    output logic [WORD_W-1:0]   word_o
);

    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [BYTE_IDX_W-1:0]    idx_q;

    always_comb begin
        word_valid_o = byte_valid_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
        word_o       = {shift_q, byte_i};
    end

    // The 2-bit index wraps naturally back to 0 after the 4th byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
            idx_q   <= idx_q + BYTE_IDX_W'(1);
        end
    end

endmodule

// File: rtl/code_mem_loader.sv
// Boot loader: receives a word count and program bytes over a valid/ready stream,
// writes them into code memory and releases the CPU once the program is resident.
module code_mem_loader
    import code_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                cpu_run,
    output logic                busy,
    output logic                err
);

    loader_state_e          state_q, state_d;
    logic [BYTE_W-1:0]      countHi_q, countHi_d;
    logic [COUNT_W-1:0]     wordTotal_q, wordTotal_d;
    logic [WORD_CNT_W-1:0]  wordCnt_q, wordCnt_d;
    logic                   memWe_q, memWe_d;
    logic [ADDR_W-1:0]      memAddr_q, memAddr_d;
    logic [WORD_W-1:0]      memWdata_q, memWdata_d;

    logic                   byteFire;
    logic                   startAcc;
    logic                   wordValid;
    logic [WORD_W-1:0]      asmWord;
    logic [COUNT_W-1:0]     headerCount;
    logic                   lastWord;

    assign byteFire    = in_valid & in_ready;
    assign startAcc    = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
    assign headerCount = {countHi_q, in_data};
    assign lastWord    = (COUNT_W'(wordCnt_q) + COUNT_W'(1)) == wordTotal_q;

    // A restart from DONE/ERR also flushes any half-assembled word.
    byte_assembler u_byte_assembler (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (startAcc),
        .byte_valid_i (byteFire && (state_q == LOAD)),
        .byte_i       (in_data),
        .word_valid_o (wordValid),
        .word_o       (asmWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: if (start) state_d = HDR_HI;
            HDR_HI:          if (byteFire) state_d = HDR_LO;
            HDR_LO: begin
                if (byteFire) begin
                    if (headerCount == '0)                        state_d = DONE;
                    else if (headerCount > COUNT_W'(MAX_WORDS))   state_d = ERR;
                    else                                          state_d = LOAD;
                end
            end
            LOAD:            if (wordValid && lastWord) state_d = FLUSH;
            FLUSH:           state_d = DONE;
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_run  = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            HDR_HI, HDR_LO, LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            FLUSH:   busy    = 1'b1;
            DONE:    cpu_run = 1'b1;
            ERR:     err     = 1'b1;
            default: ;
        endcase
    end

    // Address and data only move alongside a write strobe, so they hold between writes.
    always_comb begin
        countHi_d   = countHi_q;
        wordTotal_d = wordTotal_q;
        wordCnt_d   = wordCnt_q;
        memWe_d     = 1'b0;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        if (startAcc) wordCnt_d = '0;
        if (byteFire && (state_q == HDR_HI)) countHi_d = in_data;
        if (byteFire && (state_q == HDR_LO)) wordTotal_d = headerCount;
        if (wordValid) begin
            memWe_d    = 1'b1;
            memAddr_d  = ADDR_W'(wordCnt_q);
            memWdata_d = asmWord;
            wordCnt_d  = wordCnt_q + WORD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countHi_q   <= '0;
            wordTotal_q <= '0;
            wordCnt_q   <= '0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
        end else begin
            countHi_q   <= countHi_d;
            wordTotal_q <= wordTotal_d;
            wordCnt_q   <= wordCnt_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
        end
    end

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule
